// File: rtl/random_pkg.sv
// -----------------------------------------------------------------------------
// random_pkg
// Shared definitions for the random_gen move source:
//   - one-hot FSM state codes (INI / READY / DRAW / DONE)
//   - Galois LFSR tap masks for the supported widths (8, 16, 32)
//   - lfsr_taps(width)        : tap mask for a given LFSR width
//   - lfsr_step(width, value) : one right-shift Galois step
// -----------------------------------------------------------------------------
package random_pkg;

    localparam logic [3:0] ST_INI_OH   = 4'b0001;
    localparam logic [3:0] ST_READY_OH = 4'b0010;
    localparam logic [3:0] ST_DRAW_OH  = 4'b0100;
    localparam logic [3:0] ST_DONE_OH  = 4'b1000;

    typedef enum logic [3:0] {
        ST_INI   = ST_INI_OH,
        ST_READY = ST_READY_OH,
        ST_DRAW  = ST_DRAW_OH,
        ST_DONE  = ST_DONE_OH
    } state_e;

    // Maximal-length right-shift Galois masks.
    localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_32 = 32'hA300_0000;

    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            8:       taps = TAPS_8;
            32:      taps = TAPS_32;
            default: taps = TAPS_16;
        endcase
        return taps;
    endfunction

    // The shifted-out bit decides whether the tap mask is folded back in.
    function automatic logic [31:0] lfsr_step(input int unsigned width,
                                              input logic [31:0] value);
        logic [31:0] nxt;
        nxt = value >> 1;
        if (value[0]) begin
            nxt = nxt ^ lfsr_taps(width);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/random_lfsr.sv
// -----------------------------------------------------------------------------
// random_lfsr
// LFSR state register for random_gen: Galois step, entropy mixing, seed load
// and zero guard (a zero next value is replaced by the default seed so the
// generator can never lock up).
// Ports:
//   clk_i      system clock
//   rst_ni     synchronous reset, active low (loads init_i)
//   init_i     value loaded during reset
//   step_en_i  advance the LFSR this cycle
//   seed_ld_i  load seed_i instead of stepping (has priority)
//   seed_i     seed value
//   mix_en_i   xor mix_i into the stepped value
//   mix_i      entropy word
//   cand_o     low MOVE_W bits of the LFSR (draw candidate)
// -----------------------------------------------------------------------------
module random_lfsr
    import random_pkg::*;
#(
    parameter int                LFSR_W   = 16,
    parameter int                MOVE_W   = 2,
    parameter logic [LFSR_W-1:0] SEED_DEF = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [LFSR_W-1:0] init_i,
    input  logic              step_en_i,
    input  logic              seed_ld_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              mix_en_i,
    input  logic [LFSR_W-1:0] mix_i,
    output logic [MOVE_W-1:0] cand_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] pre_guard;
    logic [LFSR_W-1:0] init_guarded;

    always_comb begin
        pre_guard = lfsr_q;
        if (seed_ld_i) begin
            pre_guard = seed_i;
        end else if (step_en_i) begin
            pre_guard = LFSR_W'(lfsr_step(LFSR_W, 32'(lfsr_q)));
            if (mix_en_i) begin
                pre_guard = pre_guard ^ mix_i;
            end
        end
        lfsr_d = (pre_guard == '0) ? SEED_DEF : pre_guard;
    end

    assign init_guarded = (init_i == '0) ? SEED_DEF : init_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q <= init_guarded;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign cand_o = lfsr_q[MOVE_W-1:0];

endmodule

// File: rtl/random_gen.sv
// -----------------------------------------------------------------------------
// random_gen
// Pseudo-random move source for the CPU opponent. A free-running Galois LFSR,
// perturbed by player-input change events, is sampled by rejection into
// 0..NUM_MOVES-1 and delivered over a Req / Valid / Ack handshake.
// Optional build macro: RANDOM_NOREPEAT_EN -- keeps the last two delivered
// moves and refuses a third identical move in a row.
// Ports:
//   Clk      system clock
//   Reset    synchronous reset, active low
//   I        player input (entropy source)
//   Req      draw request (level, sampled in READY)
//   Ack      consumer accepts Move (DONE -> READY)
//   Seed_Ld  load Seed into the LFSR (priority over Req)
//   Seed     seed value
//   Move     drawn move, stable while Valid
//   Valid    Move valid, held until Ack
//   Busy     high while drawing
//   q_Ini, q_Ready, q_Draw, q_Done  one-hot state bits
// -----------------------------------------------------------------------------
module random_gen
    import random_pkg::*;
#(
    parameter int          LFSR_W       = 16,
    parameter int          IN_W         = 2,
    parameter int          CNT_W        = 4,
    parameter int          NUM_MOVES    = 3,
    parameter int          MOVE_W       = 2,
    parameter int          MAX_TRIES    = 8,
    parameter logic [31:0] SEED_DEFAULT = 32'h0000_ACE1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [IN_W-1:0]   I,
    input  logic              Req,
    input  logic              Ack,
    input  logic              Seed_Ld,
    input  logic [LFSR_W-1:0] Seed,
    output logic [MOVE_W-1:0] Move,
    output logic              Valid,
    output logic              Busy,
    output logic              q_Ini,
    output logic              q_Ready,
    output logic              q_Draw,
    output logic              q_Done
);

    localparam int                TRY_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [LFSR_W-1:0] SEED_W = LFSR_W'(SEED_DEFAULT);

    state_e            state_q, state_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [MOVE_W-1:0] move_q, move_d;
    logic [CNT_W-1:0]  ev_cnt_q;
    logic [IN_W-1:0]   i_prev_q;

    logic              in_event;
    logic [CNT_W-1:0]  ev_cnt_new;
    logic [MOVE_W-1:0] cand;
    logic              in_range;
    logic              cand_rep;
    logic              fb_rep;
    logic              last_try;
    logic [MOVE_W-1:0] fb_raw;
    logic [MOVE_W-1:0] fb_move;

    // Entropy: every change of I bumps the event counter and is mixed in.
    assign in_event   = (I != i_prev_q);
    assign ev_cnt_new = ev_cnt_q + CNT_W'(1);

    random_lfsr #(
        .LFSR_W   (LFSR_W),
        .MOVE_W   (MOVE_W),
        .SEED_DEF (SEED_W)
    ) u_lfsr (
        .clk_i     (Clk),
        .rst_ni    (Reset),
        .init_i    (SEED_W ^ LFSR_W'(I)),
        .step_en_i (state_q != ST_INI && !Seed_Ld),
        .seed_ld_i (state_q != ST_INI && Seed_Ld),
        .seed_i    (Seed),
        .mix_en_i  (in_event),
        .mix_i     (LFSR_W'({ev_cnt_new, I})),
        .cand_o    (cand)
    );

    assign in_range = (int'(cand) < NUM_MOVES);
    assign last_try = ((int'(tries_q) + 1) == MAX_TRIES);
    // Out-of-range candidates fold back by subtraction; because NUM_MOVES is
    // more than half the code space the result is always a legal move.
    assign fb_raw   = in_range ? cand : MOVE_W'(int'(cand) - NUM_MOVES);
    assign fb_move  = !fb_rep ? fb_raw :
                      ((int'(fb_raw) + 1 == NUM_MOVES) ? '0 : fb_raw + MOVE_W'(1));

`ifdef RANDOM_NOREPEAT_EN
    logic [MOVE_W-1:0] hist0_q, hist1_q;
    logic              hist_one_q, hist_full_q;

    assign cand_rep = hist_full_q && (cand == hist0_q) && (cand == hist1_q);
    assign fb_rep   = hist_full_q && (fb_raw == hist0_q) && (fb_raw == hist1_q);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            hist0_q     <= '0;
            hist1_q     <= '0;
            hist_one_q  <= 1'b0;
            hist_full_q <= 1'b0;
        end else if (state_q == ST_DRAW && state_d == ST_DONE) begin
            hist1_q     <= hist0_q;
            hist0_q     <= move_d;
            hist_one_q  <= 1'b1;
            hist_full_q <= hist_one_q;
        end
    end
`else
    assign cand_rep = 1'b0;
    assign fb_rep   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        move_d  = move_q;
        case (state_q)
            ST_INI: begin
                state_d = ST_READY;
            end
            ST_READY: begin
                if (Req && !Seed_Ld) begin
                    state_d = ST_DRAW;
                    tries_d = '0;
                end
            end
            ST_DRAW: begin
                if (in_range && !cand_rep) begin
                    move_d  = cand;
                    state_d = ST_DONE;
                end else if (last_try) begin
                    move_d  = fb_move;
                    state_d = ST_DONE;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            ST_DONE: begin
                if (Ack) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_INI;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= ST_INI;
            tries_q  <= '0;
            move_q   <= '0;
            ev_cnt_q <= '0;
            i_prev_q <= I;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            move_q  <= move_d;
            if (in_event) begin
                i_prev_q <= I;
                ev_cnt_q <= ev_cnt_new;
            end
        end
    end

    assign Move    = move_q;
    assign q_Ini   = (state_q == ST_INI);
    assign q_Ready = (state_q == ST_READY);
    assign q_Draw  = (state_q == ST_DRAW);
    assign q_Done  = (state_q == ST_DONE);
    assign Valid   = q_Done;
    assign Busy    = q_Draw;

endmodule

// File: tb/tb_random_gen.sv
// -----------------------------------------------------------------------------
// tb_random_gen
// Two instances share all inputs: dut (MAX_TRIES=8) and dut_ft (MAX_TRIES=1,
// always takes the first candidate or its fold-back). The LFSR sequence does
// not depend on the FSM, so both see identical candidate streams.
// -----------------------------------------------------------------------------
module tb_random_gen;

`ifdef RANDOM_NOREPEAT_EN
    localparam bit NOREP = 1'b1;
`else
    localparam bit NOREP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  I;
    logic        Req, Ack, Seed_Ld;
    logic [15:0] Seed;

    logic [1:0]  Move, Move2;
    logic        Valid, Busy, q_Ini, q_Ready, q_Draw, q_Done;
    logic        Valid2, Busy2, q_Ini2, q_Ready2, q_Draw2, q_Done2;

    always #5 Clk = ~Clk;

    random_gen dut (
        .Clk(Clk), .Reset(Reset), .I(I), .Req(Req), .Ack(Ack),
        .Seed_Ld(Seed_Ld), .Seed(Seed), .Move(Move), .Valid(Valid),
        .Busy(Busy), .q_Ini(q_Ini), .q_Ready(q_Ready), .q_Draw(q_Draw),
        .q_Done(q_Done)
    );

    random_gen #(.MAX_TRIES(1)) dut_ft (
        .Clk(Clk), .Reset(Reset), .I(I), .Req(Req), .Ack(Ack),
        .Seed_Ld(Seed_Ld), .Seed(Seed), .Move(Move2), .Valid(Valid2),
        .Busy(Busy2), .q_Ini(q_Ini2), .q_Ready(q_Ready2), .q_Draw(q_Draw2),
        .q_Done(q_Done2)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [15:0] m_lfsr;
    logic [1:0]  m_prev;
    int          m_cnt;
    bit          m_ini;
    int          h0[2], h1[2], hn[2];

    typedef struct {
        logic [15:0] seed;
        logic [15:0] lfsr_exp;
        int          move;
        int          lat;
        int          move2;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step16(input logic [15:0] v);
        return (v >> 1) ^ ((v % 16'd2 == 16'd1) ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] guard16(input logic [15:0] v);
        return (v == 16'h0000) ? 16'hACE1 : v;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit ev;
        int nc;
        if (!Reset) begin
            m_lfsr = guard16(16'hACE1 ^ {14'b0, I});
            m_prev = I;
            m_cnt  = 0;
            m_ini  = 1'b1;
        end else begin
            ev = (I != m_prev);
            nc = (m_cnt + 1) % 16;
            if (m_ini) begin
                m_ini = 1'b0;
            end else if (Seed_Ld) begin
                m_lfsr = guard16(Seed);
            end else begin
                m_lfsr = guard16(step16(m_lfsr) ^ (ev ? 16'(nc * 4 + int'(I)) : 16'h0000));
            end
            if (ev) begin
                m_prev = I;
                m_cnt  = nc;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    function automatic bit is_rep(input int idx, input int v);
        return NOREP && hn[idx] == 2 && v == h0[idx] && v == h1[idx];
    endfunction

    // Walk the candidate stream: first acceptable value, else fold-back.
    function automatic void predict(input logic [15:0] l0, input int maxt, input int idx,
                                    output int mv, output int rej);
        logic [15:0] l;
        int c, f;
        l = l0; mv = 0; rej = 0;
        for (int t = 0; t < maxt; t++) begin
            c = int'(l % 16'd4);
            if (c < 3 && !is_rep(idx, c)) begin
                mv = c; rej = t; return;
            end
            if (t == maxt - 1) begin
                f = (c < 3) ? c : c - 3;
                if (is_rep(idx, f)) f = (f + 1) % 3;
                mv = f; rej = t; return;
            end
            l = step16(l);
        end
    endfunction

    task automatic record_hist(input int idx, input int mv);
        h1[idx] = h0[idx];
        h0[idx] = mv;
        if (hn[idx] < 2) hn[idx]++;
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 2; k++) begin
            h0[k] = 0; h1[k] = 0; hn[k] = 0;
        end
    endtask

    task automatic apply_reset();
        Reset = 1'b0; Req = 1'b0; Ack = 1'b0; Seed_Ld = 1'b0;
        tick();
        tick();
        clear_hist();
        Reset = 1'b1;
        tick();
    endtask

    task automatic load_seed(input logic [15:0] s);
        Seed = s; Seed_Ld = 1'b1;
        tick();
        Seed_Ld = 1'b0;
    endtask

    // One full Req/Valid/Ack transaction. With use_model the expectations are
    // recomputed from the reference model after the request edge.
    task automatic draw(input string tag, input int exp_mv, input int exp_lat,
                        input int exp_mv2, input bit use_model, input int hold,
                        input bit rand_i);
        int lat, busy_cnt, rej, mv2, rej2;
        Req = 1'b1;
        tick();
        Req = 1'b0;
        if (use_model) begin
            predict(m_lfsr, 8, 0, exp_mv, rej);
            predict(m_lfsr, 1, 1, mv2, rej2);
            exp_lat = rej + 2;
            exp_mv2 = mv2;
        end
        lat = 1; busy_cnt = 0;
        while (!Valid && lat < 40) begin
            if (Busy) busy_cnt++;
            tick();
            lat++;
        end
        check({tag, "_valid"}, 32'(Valid), 32'd1);
        check({tag, "_move"}, 32'(Move), 32'(exp_mv));
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        check({tag, "_ft_valid"}, 32'(Valid2), 32'd1);
        check({tag, "_ft_move"}, 32'(Move2), 32'(exp_mv2));
        record_hist(0, exp_mv);
        record_hist(1, exp_mv2);
        for (int k = 0; k < hold; k++) begin
            if (rand_i) I = 2'($urandom_range(0, 3));
            tick();
            check({tag, "_hold_move"}, 32'(Move), 32'(exp_mv));
            check({tag, "_hold_valid"}, 32'(Valid), 32'd1);
        end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check({tag, "_ack_valid"}, 32'(Valid), 32'd0);
        check({tag, "_ack_ready"}, 32'(q_Ready), 32'd1);
        check({tag, "_ack_ft_valid"}, 32'(Valid2), 32'd0);
        check({tag, "_lfsr"}, 32'(dut.u_lfsr.lfsr_q), 32'(m_lfsr));
        $display("draw %s: move=%0d latency=%0d ft_move=%0d", tag, Move, lat, Move2);
    endtask

    initial begin
        tbl[0] = '{16'h0004, 16'h0004, 2, 2, 2};
        tbl[1] = '{16'h0006, 16'h0006, 1, 3, 0};
        tbl[2] = '{16'h0000, 16'hACE1, 0, 2, 0};
        tbl[3] = '{16'h0003, 16'h0003, 1, 2, 1};
        tbl[4] = '{16'h000F, 16'h000F, 1, 4, 0};
        tbl[5] = '{16'h0008, 16'h0008, 0, 2, 0};

        I = 2'b01; Seed = 16'h0000;
        Reset = 1'b1; Req = 1'b0; Ack = 1'b0; Seed_Ld = 1'b0;
        clear_hist();

        // Reset state
        Reset = 1'b0;
        tick();
        tick();
        check("rst_q_ini", 32'(q_Ini), 32'd1);
        check("rst_valid", 32'(Valid), 32'd0);
        check("rst_move", 32'(Move), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'h0000_ACE0);
        check("rst_evcnt", 32'(dut.ev_cnt_q), 32'd0);
        Reset = 1'b1;
        clear_hist();
        tick();
        check("rel_q_ready", 32'(q_Ready), 32'd1);
        check("rel_lfsr_hold", 32'(dut.u_lfsr.lfsr_q), 32'h0000_ACE0);
        $display("reset: q_Ini->q_Ready lfsr=%h", dut.u_lfsr.lfsr_q);

        // Directed seed table
        for (int v = 0; v < 6; v++) begin
            load_seed(tbl[v].seed);
            check($sformatf("tbl%0d_seed_lfsr", v), 32'(dut.u_lfsr.lfsr_q), 32'(tbl[v].lfsr_exp));
            draw($sformatf("tbl%0d", v), tbl[v].move, tbl[v].lat, tbl[v].move2, 1'b0, 1, 1'b0);
        end

        // Seed_Ld has priority over Req
        Seed = 16'h0004; Seed_Ld = 1'b1; Req = 1'b1;
        tick();
        Seed_Ld = 1'b0; Req = 1'b0;
        check("seed_prio_ready", 32'(q_Ready), 32'd1);
        check("seed_prio_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'h0000_0004);
        $display("seed priority: q_Ready=%0d", q_Ready);

        // Reset mid-draw aborts without Valid
        load_seed(16'h000F);
        Req = 1'b1;
        tick();
        Req = 1'b0;
        tick();
        check("abort_in_draw", 32'(Busy), 32'd1);
        Reset = 1'b0;
        tick();
        check("abort_valid", 32'(Valid), 32'd0);
        check("abort_q_ini", 32'(q_Ini), 32'd1);
        check("abort_busy", 32'(Busy), 32'd0);
        Reset = 1'b1;
        clear_hist();
        tick();
        $display("abort: reset mid-draw returned to INI");

        // Entropy: 17 input changes wrap the 4-bit counter to 1
        for (int k = 0; k < 17; k++) begin
            I = ~I;
            tick();
        end
        check("ev_cnt_wrap", 32'(dut.ev_cnt_q), 32'd1);
        check("ev_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'(m_lfsr));
        tick();
        check("ev_no_change", 32'(dut.ev_cnt_q), 32'd1);
        // Seed load and event in the same cycle: seed wins, counter counts
        I = ~I; Seed = 16'h1234; Seed_Ld = 1'b1;
        tick();
        Seed_Ld = 1'b0;
        check("ev_seed_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'h0000_1234);
        check("ev_seed_cnt", 32'(dut.ev_cnt_q), 32'd2);
        $display("entropy: ev_cnt=%0d lfsr=%h", dut.ev_cnt_q, dut.u_lfsr.lfsr_q);

        // No-repeat scenario: two draws of 1, then a candidate of 1 again
        apply_reset();
        load_seed(16'h0003);
        draw("rep0", 1, 2, 1, 1'b0, 0, 1'b0);
        load_seed(16'h0003);
        draw("rep1", 1, 2, 1, 1'b0, 0, 1'b0);
        load_seed(16'h0003);
        draw("rep2", NOREP ? 0 : 1, NOREP ? 3 : 2, NOREP ? 2 : 1, 1'b0, 0, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            int idle;
            idle = $urandom_range(0, 5);
            for (int k = 0; k < idle; k++) begin
                I = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) begin
                    Seed = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
                    Seed_Ld = 1'b1;
                end
                tick();
                Seed_Ld = 1'b0;
                check($sformatf("rnd%0d_idle_lfsr", n), 32'(dut.u_lfsr.lfsr_q), 32'(m_lfsr));
            end
            draw($sformatf("rnd%0d", n), 0, 0, 0, 1'b1, $urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
